bsg_gateway_uart_rx: RTL
========================

# bsg_gateway_uart_rx

Oversampling UART receiver inside the gateway FPGA that consumes the board-level `UART_RX` line and delivers received bytes to gateway control logic over a valid/yumi interface. It synchronizes the asynchronous pin, frames 8N1 characters, rejects start-bit glitches, flags framing errors, and buffers bytes in a small FIFO so a slow consumer does not lose characters.

## Interface
- `clk_div_p`, default 1302: clocks per bit; 150 MHz oscillator / 115200 baud. Must be ≥ 4.
- `els_p`, default 4: FIFO depth; power of 2, ≥ 2.
- `clk_i`  input  1  gateway core clock.
- `reset_n_i`  input  1  reset; one clock; reset is asynchronous and active-low.
- `rx_i`  input  1  raw `UART_RX` pin; asynchronous; idle high.
- `data_o`  output  8  byte at FIFO head.
- `v_o`  output  1  `data_o` valid.
- `yumi_i`  input  1  consumer takes head byte this cycle; legal only when `v_o`=1.
- `frame_err_o`  output  1  one-cycle pulse on bad stop bit.
- `overflow_o`  output  1  sticky; byte dropped because FIFO was full.
- `clear_i`  input  1  clears `overflow_o`.

## Operation
- Synchronizer: 2 flops on `rx_i`, both reset to 1; FSM sees only `rx_s`.
- Bit counter `cnt` counts down, width `$clog2(clk_div_p)`; bit index 0..7.
- States:
  - IDLE: `rx_s`=0 → START, `cnt`=floor(clk_div_p/2)-1.
  - START: at `cnt`=0 sample `rx_s`; 0 → DATA, `cnt`=clk_div_p-1, index=0; 1 → IDLE (glitch, nothing recorded).
  - DATA: at `cnt`=0 shift `rx_s` into shift register LSB first, reload `cnt`; after index 7 → STOP, `cnt`=clk_div_p-1.
  - STOP: at `cnt`=0 sample `rx_s`. 1 → push byte, → IDLE. 0 → pulse `frame_err_o`, discard byte, → WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1 (break/line-low), then → IDLE.
- FIFO: `els_p` entries, head on `data_o`. Push with FIFO full and no simultaneous `yumi_i` → byte dropped, `overflow_o` set. Full + `yumi_i` same cycle as push → push accepted, no overflow.
- `overflow_o`: set wins over `clear_i` in the same cycle.
- `yumi_i` while `v_o`=0 is illegal; assertion in simulation, no state change.

## Timing
- Reset (async assert, sync-released use): state IDLE, `cnt`=0, FIFO empty, `v_o`=0, `data_o`=0, `frame_err_o`=0, `overflow_o`=0, sync flops 1.
- Falling edge on `rx_i` first captured at edge T: `rx_s` low at T+2; START sample at T+2+floor(D/2); bit k sample at T+2+floor(D/2)+(k+1)·D; stop sample at T+2+floor(D/2)+9·D (D=`clk_div_p`).
- Push occurs in the stop-sample cycle; `v_o`=1 the following cycle (1-cycle FIFO latency).
- `yumi_i` pops at the clock edge; next entry (if any) on `data_o` the following cycle.
- `frame_err_o` high exactly the cycle after the stop sample.
- Back-to-back characters: new start bit accepted from IDLE the cycle after STOP; no dead time beyond the half-stop-bit margin.
- Reset mid-character: byte lost, FIFO flushed, no error/overflow flagged after release; receiver resynchronizes on next falling edge only after `rx_s` observed in IDLE.

## Test plan
- `clk_div_p`=16, send 0xA5 8N1 → `v_o` rises at T+2+8+144+1, `data_o`=0xA5; `yumi_i` → `v_o`=0 next cycle.
- `clk_div_p`=16, `els_p`=4, send 0x01..0x05 with `yumi_i`=0 → FIFO holds 0x01..0x04, `overflow_o`=1 after 5th stop bit; `clear_i` → 0; drain yields 0x01,0x02,0x03,0x04.
- FIFO full, `yumi_i` asserted in the exact cycle of 5th byte's stop sample → no overflow; drain yields 0x02..0x05.
- Send 0x3C with stop bit driven 0, then line held low 40 cycles → `frame_err_o` one pulse, no byte; next 0x7E received correctly.
- 5-cycle low glitch on idle line (`clk_div_p`=16) → no byte, no error, FSM back in IDLE.
- Assert `reset_n_i` low during bit 4 of 0x55 with 2 bytes queued → `v_o`=0, FIFO empty; following 0xC3 received correctly.

Source files
------------

// File: rtl/bsg_gateway_uart_rx.sv
// Oversampling 8N1 UART receiver with start-glitch rejection, framing-error pulse
// and a small valid/yumi output FIFO with sticky overflow.
module bsg_gateway_uart_rx #(
    parameter int unsigned clk_div_p = 1302,
    parameter int unsigned els_p     = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       v_o,
    input  logic       yumi_i,
    output logic       frame_err_o,
    output logic       overflow_o,
    input  logic       clear_i
);

    localparam int unsigned CntW = $clog2(clk_div_p);
    localparam int unsigned PtrW = $clog2(els_p);

    localparam logic [CntW-1:0] CntFull = CntW'(clk_div_p - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(clk_div_p / 2 - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW:0]   FifoCap = (PtrW + 1)'(els_p);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitHigh = 3'd4;

    logic [1:0]      sync_q;
    logic            rx_s;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            push;

    logic [7:0]      mem_q [els_p];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            full, pop, push_ok, drop;
    logic            overflow_q;

    // Idle-high line, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = CntHalf;
                end
            end
            StStart: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d = StData;
                        cnt_d   = CntFull;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = CntFull;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StStop: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWaitHigh: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err_o = frame_err_q;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign full    = (count_q == FifoCap);
    assign v_o     = (count_q != '0);
    assign pop     = yumi_i & v_o;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign data_o     = v_o ? mem_q[rd_ptr_q] : 8'h00;
    assign overflow_o = overflow_q;

    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

endmodule
